// File: rtl/tile_dispatch_scheduler.sv
// rtl/tile_dispatch_scheduler.sv - walks a triangle's covered 8x8 tiles and issues them to the tile evaluator
// Optional build macro: TILE_SERPENTINE_EN (boustrophedon row order instead of plain raster order).
module tile_dispatch_scheduler #(
  parameter int COORD_W         = 11,
  parameter int TILE_SHIFT      = 3,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [COORD_W-1:0]            bbox_min_x,
  input  logic [COORD_W-1:0]            bbox_min_y,
  input  logic [COORD_W-1:0]            bbox_max_x,
  input  logic [COORD_W-1:0]            bbox_max_y,
  input  logic                          frag_buf_ready,
  input  logic                          tile_ready,
  input  logic                          tile_ack,
  output logic                          tile_valid,
  output logic [COORD_W-TILE_SHIFT-1:0] tile_x,
  output logic [COORD_W-TILE_SHIFT-1:0] tile_y,
  output logic                          tile_last,
  output logic                          busy,
  output logic                          done,
  output logic                          empty,
  output logic [CNT_W-1:0]              tile_count
);

  localparam int TW = COORD_W - TILE_SHIFT;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] MAX_O = OW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Tile-space bounds of the current triangle and the cursor (next tile to offer).
  logic [TW-1:0] r_tx0, r_tx1, r_ty0, r_ty1;
  logic [TW-1:0] r_cx, r_cy;
  logic          r_dir;        // 1 = current row walks right-to-left

  logic [OW-1:0]    r_outstanding;
  logic             r_tile_valid;
  logic [TW-1:0]    r_tile_x, r_tile_y;
  logic             r_tile_last;
  logic             r_busy, r_done, r_empty;
  logic [CNT_W-1:0] r_count;

  logic          w_inverted;
  logic          w_accept;
  logic          w_ack_eff;
  logic [OW-1:0] w_out_next;
  logic [OW-1:0] w_out_cmp;
  logic          w_offer;
  logic          w_row_end;
  logic          w_cur_last;
  logic [TW-1:0] w_sx, w_sy;
  logic          w_sdir;

  assign w_inverted = (bbox_min_x > bbox_max_x) || (bbox_min_y > bbox_max_y);
  assign w_accept   = r_tile_valid & tile_ready;
  // An ack with nothing outstanding is stray (e.g. left over from an aborted triangle).
  assign w_ack_eff  = tile_ack && (r_outstanding != '0);

  // Outstanding count after this edge: accept and ack together cancel out.
  always_comb begin
    w_out_next = r_outstanding;
    if (w_accept && !w_ack_eff) begin
      w_out_next = r_outstanding + OW'(1);
    end else if (!w_accept && w_ack_eff) begin
      w_out_next = r_outstanding - OW'(1);
    end
  end

  // Cursor is at the end of its row in the direction it is travelling; the last tile is that end on row ty1.
  assign w_row_end  = r_dir ? (r_cx == r_tx0) : (r_cx == r_tx1);
  assign w_cur_last = w_row_end && (r_cy == r_ty1);

  // Successor of the cursor tile in traversal order.
  always_comb begin
    w_sx   = r_cx;
    w_sy   = r_cy;
    w_sdir = r_dir;
`ifdef TILE_SERPENTINE_EN
    if (w_row_end) begin
      w_sy   = r_cy + TW'(1);
      w_sdir = ~r_dir;
    end else if (r_dir) begin
      w_sx = r_cx - TW'(1);
    end else begin
      w_sx = r_cx + TW'(1);
    end
`else
    w_sdir = 1'b0;
    if (w_row_end) begin
      w_sx = r_tx0;
      w_sy = r_cy + TW'(1);
    end else begin
      w_sx = r_cx + TW'(1);
    end
`endif
  end

  // After an acceptance the limit is judged on the post-update count so issue can run back-to-back.
  assign w_out_cmp = w_accept ? w_out_next : r_outstanding;
  assign w_offer   = (r_state == S_ISSUE) && !(r_tile_valid && !tile_ready) &&
                     !(w_accept && r_tile_last) && (w_out_cmp < MAX_O) && frag_buf_ready;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = w_inverted ? S_DONE : S_ISSUE;
      S_ISSUE: if (w_accept && r_tile_last) w_state_next = S_DRAIN;
      S_DRAIN: if (w_out_next == '0) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Bounds latch, cursor walk, registered tile stream, counters and status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx0         <= '0;
      r_tx1         <= '0;
      r_ty0         <= '0;
      r_ty1         <= '0;
      r_cx          <= '0;
      r_cy          <= '0;
      r_dir         <= 1'b0;
      r_outstanding <= '0;
      r_tile_valid  <= 1'b0;
      r_tile_x      <= '0;
      r_tile_y      <= '0;
      r_tile_last   <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_empty       <= 1'b0;
      r_count       <= '0;
    end else begin
      r_done        <= 1'b0;
      r_outstanding <= w_out_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_tx0   <= bbox_min_x[COORD_W-1:TILE_SHIFT];
            r_tx1   <= bbox_max_x[COORD_W-1:TILE_SHIFT];
            r_ty0   <= bbox_min_y[COORD_W-1:TILE_SHIFT];
            r_ty1   <= bbox_max_y[COORD_W-1:TILE_SHIFT];
            r_cx    <= bbox_min_x[COORD_W-1:TILE_SHIFT];
            r_cy    <= bbox_min_y[COORD_W-1:TILE_SHIFT];
            r_dir   <= 1'b0;
            r_count <= '0;
            r_empty <= w_inverted;
            r_busy  <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (w_accept && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + CNT_W'(1);
          end
          if (w_offer) begin
            r_tile_valid <= 1'b1;
            r_tile_x     <= r_cx;
            r_tile_y     <= r_cy;
            r_tile_last  <= w_cur_last;
            r_cx         <= w_sx;
            r_cy         <= w_sy;
            r_dir        <= w_sdir;
          end else if (w_accept) begin
            r_tile_valid <= 1'b0;
            r_tile_last  <= 1'b0;
          end
        end
        S_DONE: begin
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign tile_valid = r_tile_valid;
  assign tile_x     = r_tile_x;
  assign tile_y     = r_tile_y;
  assign tile_last  = r_tile_last;
  assign busy       = r_busy;
  assign done       = r_done;
  assign empty      = r_empty;
  assign tile_count = r_count;

endmodule

// File: tb/tb_tile_dispatch_scheduler.sv
// tb/tb_tile_dispatch_scheduler.sv - self-checking bench for tile_dispatch_scheduler
module tb_tile_dispatch_scheduler;

  localparam int COORD_W = 11;
  localparam int TS      = 3;
  localparam int TW      = COORD_W - TS;
  localparam int CNT_W   = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [COORD_W-1:0] bbox_min_x, bbox_min_y, bbox_max_x, bbox_max_y;
  logic               frag_buf_ready, tile_ready, tile_ack;
  logic               tile_valid, tile_last, busy, done, empty;
  logic [TW-1:0]      tile_x, tile_y;
  logic [CNT_W-1:0]   tile_count;

  tile_dispatch_scheduler #(
    .COORD_W(COORD_W), .TILE_SHIFT(TS), .MAX_OUTSTANDING(4), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .bbox_min_x(bbox_min_x), .bbox_min_y(bbox_min_y),
    .bbox_max_x(bbox_max_x), .bbox_max_y(bbox_max_y),
    .frag_buf_ready(frag_buf_ready), .tile_ready(tile_ready), .tile_ack(tile_ack),
    .tile_valid(tile_valid), .tile_x(tile_x), .tile_y(tile_y), .tile_last(tile_last),
    .busy(busy), .done(done), .empty(empty), .tile_count(tile_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int minx; int miny; int maxx; int maxy;
    int exp_count;
    int exp_empty;
    int exp_done_ofs;   // edges from the start edge to the edge that raises done
  } vec_t;

  vec_t vecs[8];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int s_cyc    = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  bit auto_ack = 0;
  bit ack_all  = 0;
  int acc_x[$], acc_y[$], acc_last[$], acc_cyc[$];
  int ack_q[$];
  int exp_x[$], exp_y[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // One clock: log any acceptance at this edge, detect done, schedule acks for the next edge.
  task automatic cycle();
    logic a;
    int   ax, ay, al;
    a  = tile_valid & tile_ready;
    ax = int'(tile_x);
    ay = int'(tile_y);
    al = int'(tile_last);
    @(posedge clk);
    cyc++;
    #1;
    if (a) begin
      acc_x.push_back(ax);
      acc_y.push_back(ay);
      acc_last.push_back(al);
      acc_cyc.push_back(cyc);
      if (auto_ack) ack_q.push_back(cyc + 2);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    tile_ack = 1'b0;
    if (ack_all) begin
      tile_ack = 1'b1;
    end else if (ack_q.size() > 0 && ack_q[0] <= cyc + 1) begin
      void'(ack_q.pop_front());
      tile_ack = 1'b1;
    end
  endtask

  task automatic clear_log();
    acc_x.delete(); acc_y.delete(); acc_last.delete(); acc_cyc.delete();
    ack_q.delete();
    done_cnt = 0;
  endtask

  task automatic start_tri(input int mnx, input int mny, input int mxx, input int mxy);
    bbox_min_x = COORD_W'(mnx);
    bbox_min_y = COORD_W'(mny);
    bbox_max_x = COORD_W'(mxx);
    bbox_max_y = COORD_W'(mxy);
    start = 1'b1;
    cycle();
    start = 1'b0;
    s_cyc = cyc;
    check("busy_after_start", busy, 1);
  endtask

  task automatic run_until_done(input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      cycle();
      n++;
    end
    check("done_seen", done_cnt != d0, 1);
  endtask

  // Expected traversal order from tile-space bounds.
  task automatic build_expected(input int mnx, input int mny, input int mxx, input int mxy);
    int tx0, tx1, ty0, ty1;
    exp_x.delete();
    exp_y.delete();
    tx0 = mnx >> TS; tx1 = mxx >> TS; ty0 = mny >> TS; ty1 = mxy >> TS;
    if (mnx > mxx || mny > mxy) return;
    for (int r = 0; r <= ty1 - ty0; r++) begin
      for (int k = 0; k <= tx1 - tx0; k++) begin
`ifdef TILE_SERPENTINE_EN
        exp_x.push_back((r % 2 == 1) ? tx1 - k : tx0 + k);
`else
        exp_x.push_back(tx0 + k);
`endif
        exp_y.push_back(ty0 + r);
      end
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; tile_ack = 1'b0;
    bbox_min_x = '0; bbox_min_y = '0; bbox_max_x = '0; bbox_max_y = '0;
    frag_buf_ready = 1'b1; tile_ready = 1'b1;

    vecs[0] = '{0, 0, 15, 15, 4, 0, 8};
    vecs[1] = '{20, 0, 10, 7, 0, 1, 1};
    vecs[2] = '{0, 20, 7, 10, 0, 1, 1};
    vecs[3] = '{8, 8, 8, 8, 1, 0, 5};
    vecs[4] = '{5, 3, 30, 20, 12, 0, 16};
    vecs[5] = '{2040, 2040, 2047, 2047, 1, 0, 5};
    vecs[6] = '{0, 0, 0, 23, 3, 0, 7};
    vecs[7] = '{0, 0, 23, 15, 6, 0, 10};

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", tile_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_empty", empty, 0);
    check("rst_count", tile_count, 0);
    check("rst_last", tile_last, 0);
    rst = 1'b1;
    cycle();

    // Table: full-rate triangles, every tile acked two edges after acceptance.
    for (int v = 0; v < 8; v++) begin
      clear_log();
      auto_ack = 1; tile_ready = 1'b1; frag_buf_ready = 1'b1;
      build_expected(vecs[v].minx, vecs[v].miny, vecs[v].maxx, vecs[v].maxy);
      start_tri(vecs[v].minx, vecs[v].miny, vecs[v].maxx, vecs[v].maxy);
      run_until_done(200);
      check($sformatf("v%0d_done_ofs", v), done_cyc - s_cyc, vecs[v].exp_done_ofs);
      repeat (3) cycle();
      check($sformatf("v%0d_done_once", v), done_cnt, 1);
      check($sformatf("v%0d_accepts", v), acc_x.size(), vecs[v].exp_count);
      check($sformatf("v%0d_tile_count", v), tile_count, vecs[v].exp_count);
      check($sformatf("v%0d_empty", v), empty, vecs[v].exp_empty);
      check($sformatf("v%0d_busy_low", v), busy, 0);
      for (int i = 0; i < acc_x.size() && i < exp_x.size(); i++) begin
        check($sformatf("v%0d_t%0d_x", v, i), acc_x[i], exp_x[i]);
        check($sformatf("v%0d_t%0d_y", v, i), acc_y[i], exp_y[i]);
        check($sformatf("v%0d_t%0d_last", v, i), acc_last[i], (i == exp_x.size() - 1) ? 1 : 0);
        check($sformatf("v%0d_t%0d_cyc", v, i), acc_cyc[i] - s_cyc, 2 + i);
      end
    end

    // Outstanding limit: no acks, then one ack, then ack everything.
    clear_log();
    auto_ack = 0;
    start_tri(0, 0, 63, 7);
    repeat (8) cycle();
    check("lim_accepts", acc_x.size(), 4);
    for (int i = 0; i < acc_x.size(); i++) check($sformatf("lim_x%0d", i), acc_x[i], i);
    check("lim_valid_low", tile_valid, 0);
    tile_ack = 1'b1;
    cycle();
    check("lim_ack_edge_valid", tile_valid, 0);
    cycle();
    check("lim_reoffer_valid", tile_valid, 1);
    check("lim_reoffer_x", tile_x, 4);
    ack_all = 1;
    run_until_done(100);
    check("lim_total", acc_x.size(), 8);
    check("lim_tile_count", tile_count, 8);
    repeat (3) cycle();
    ack_all = 0;
    cycle();
    check("lim_busy_low", busy, 0);

    // Abort mid-issue with 3 outstanding; stray acks afterwards must not disturb the next triangle.
    clear_log();
    auto_ack = 0;
    start_tri(0, 0, 63, 7);
    repeat (8) cycle();
    check("abort_accepts", acc_x.size(), 4);
    tile_ready = 1'b0;
    tile_ack = 1'b1;
    cycle();
    cycle();
    check("abort_pend_valid", tile_valid, 1);
    check("abort_pend_x", tile_x, 4);
    rst = 1'b0;
    #1;
    check("abort_valid", tile_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_x", tile_x, 0);
    check("abort_count", tile_count, 0);
    check("abort_last", tile_last, 0);
    tile_ready = 1'b1;
    cycle();
    cycle();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tile_ack = 1'b1;
      cycle();
    end
    clear_log();
    auto_ack = 1;
    start_tri(8, 8, 8, 8);
    run_until_done(50);
    check("post_abort_accepts", acc_x.size(), 1);
    if (acc_x.size() > 0) begin
      check("post_abort_x", acc_x[0], 1);
      check("post_abort_y", acc_y[0], 1);
      check("post_abort_last", acc_last[0], 1);
    end
    check("post_abort_count", tile_count, 1);

    // Frag-buffer gating and a 5-cycle stall on tile (2,1); start during ISSUE is ignored.
    clear_log();
    auto_ack = 1;
    frag_buf_ready = 1'b0;
    start_tri(0, 0, 31, 15);
    for (int k = 0; k < 3; k++) begin
      cycle();
      check($sformatf("gate_valid_%0d", k), tile_valid, 0);
    end
    frag_buf_ready = 1'b1;
    begin
      bit found;
      found = 0;
      for (int n = 0; n < 40 && !found; n++) begin
        cycle();
        if (tile_valid && tile_x == 2 && tile_y == 1) found = 1;
      end
      check("stall_found", found, 1);
    end
    tile_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      frag_buf_ready = (k % 2 == 0);
      start = (k == 2);
      cycle();
      check($sformatf("stall_valid_%0d", k), tile_valid, 1);
      check($sformatf("stall_x_%0d", k), tile_x, 2);
      check($sformatf("stall_y_%0d", k), tile_y, 1);
    end
    start = 1'b0;
    tile_ready = 1'b1;
    frag_buf_ready = 1'b1;
    cycle();
    check("stall_accept_x", acc_x.size() > 0 ? acc_x[acc_x.size()-1] : -1, 2);
    check("stall_accept_y", acc_y.size() > 0 ? acc_y[acc_y.size()-1] : -1, 1);
    check("stall_accept_cyc", acc_cyc.size() > 0 ? acc_cyc[acc_cyc.size()-1] : -1, cyc);
    run_until_done(100);
    repeat (3) cycle();
    check("stall_total", acc_x.size(), 8);
    check("stall_tile_count", tile_count, 8);
    check("stall_busy_low", busy, 0);
    check("stall_done_once", done_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tile_dispatch_scheduler.md
Name: tile_dispatch_scheduler

Overview:
- Sequences the tile evaluator for one triangle.
- Takes the triangle's pixel bounding box from triangle setup and walks the covered screen tiles in raster order.
- Issues one tile coordinate per valid/ready handshake to the tile evaluator.
- Limits tiles in flight, gates issue on fragment output buffer space, and pulses done when every issued tile has been acknowledged.
- Sits between the pipeline sync controller (start/done) and the tile evaluator (tile stream).

Parameters:
- COORD_W, 11, pixel coordinate width (bbox inputs).
- TILE_SHIFT, 3, log2 of tile edge in pixels (8x8 tiles).
- MAX_OUTSTANDING, 4, maximum tiles accepted but not yet acknowledged (1..15).
- CNT_W, 16, width of tile_count.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- start  input  1  begin a triangle; sampled only in IDLE.
- bbox_min_x  input  COORD_W  inclusive min x, pixels.
- bbox_min_y  input  COORD_W  inclusive min y, pixels.
- bbox_max_x  input  COORD_W  inclusive max x, pixels.
- bbox_max_y  input  COORD_W  inclusive max y, pixels.
- frag_buf_ready  input  1  fragment output buffer can absorb another tile.
- tile_ready  input  1  evaluator accepts the offered tile.
- tile_ack  input  1  evaluator finished one previously accepted tile (1-cycle pulse).
- tile_valid  output  1  tile offered.
- tile_x  output  COORD_W-TILE_SHIFT  tile column.
- tile_y  output  COORD_W-TILE_SHIFT  tile row.
- tile_last  output  1  offered tile is the final tile of the triangle.
- busy  output  1  triangle in progress.
- done  output  1  one-cycle completion pulse.
- empty  output  1  last triangle had an inverted bbox (sticky until next start).
- tile_count  output  CNT_W  tiles accepted for the current or last triangle.

Behaviour:
- Reset: all outputs 0, state IDLE, outstanding counter 0. Reset asserted mid-operation aborts immediately; acks arriving later are ignored.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE + start at edge e:
  - Latch tx0=min_x>>TILE_SHIFT, tx1=max_x>>TILE_SHIFT, ty0, ty1; clear tile_count and empty; set busy.
  - If min_x>max_x or min_y>max_y: set empty and go to DONE.
  - Otherwise go to ISSUE with cursor (tx0,ty0).
- start outside IDLE is ignored.
- ISSUE:
  - tile_valid, tile_x, tile_y and tile_last are registered.
  - A tile is offered (valid rises at an edge) when no tile is pending, outstanding<MAX_OUTSTANDING and frag_buf_ready, all sampled at that edge. First offer is earliest one cycle after the start edge.
  - Once tile_valid=1, it and the coordinates hold stable until tile_valid&tile_ready, regardless of frag_buf_ready or outstanding.
  - On acceptance: outstanding+1, tile_count+1, cursor advances x+1. At x=tx1, x wraps to tx0 and y+1.
  - Back-to-back issue: the next tile is presented in the cycle after acceptance if the post-update outstanding<MAX and frag_buf_ready=1 at that edge. Full throughput is 1 tile/cycle.
  - Acceptance of the tile at (tx1,ty1), with tile_last=1, goes to DRAIN and drops tile_valid.
- Outstanding counter:
  - +1 on accept, -1 on tile_ack.
  - Both in the same cycle: unchanged.
  - tile_ack with outstanding=0 is ignored (no underflow).
- DRAIN: when outstanding reaches 0 (including via an ack on that edge), go to DONE.
- DONE: done=1 for exactly one cycle, busy drops on the same edge done rises, next state IDLE. tile_count and empty hold until the next start.
- Done latency for an empty bbox: done high in the 2nd cycle after the start edge.
- Arithmetic: tile coordinates are unsigned; tile_count saturates at all-ones.

Optional Feature:
- Macro TILE_SERPENTINE_EN.
- Defined: odd rows relative to ty0 traverse tx1 down to tx0; even rows traverse tx0 up to tx1. tile_last marks (tx0,ty1) when the row count is even, otherwise (tx1,ty1).
- Undefined: plain raster order as above.

Test Plan:
- bbox (0,0)-(15,15), tile_ready=1, frag_buf_ready=1, each tile acked 2 cycles after accept -> tiles (0,0),(1,0),(0,1),(1,1) on 4 consecutive cycles; tile_last on (1,1); done once after the 4th ack; tile_count=4; busy low afterwards.
- bbox (0,0)-(63,7), MAX_OUTSTANDING=4, no acks -> exactly 4 accepts (x=0..3), then tile_valid low. One ack -> tile x=4 offered next cycle. Ack all -> done after 8 tiles.
- bbox min_x=20, max_x=10 -> tile_valid never rises; empty=1; tile_count=0; done pulses 2 cycles after start.
- tile_ready held low 5 cycles with tile (2,1) offered, frag_buf_ready toggling -> tile_valid and coordinates stable all 5 cycles; accepted on the 6th.
- Reset pulled low while in ISSUE with 3 outstanding -> all outputs 0 immediately. A later start with bbox (8,8)-(8,8) -> single tile (1,1) with tile_last=1.
- TILE_SERPENTINE_EN, bbox (0,0)-(23,15) -> order (0,0),(1,0),(2,0),(2,1),(1,1),(0,1); tile_last on (0,1).
